usb_tx_block_packer: RTL and testbench

- Sits directly upstream of the USB transmitter top level.
- Accepts a byte stream from the encryption datapath and packs it into 64-bit payload blocks.
- Queues finished blocks in a small FIFO and presents them one at a time on the transmitter's trans_data / trans_data_ready / handshake_ack interface.
- Supports a flush request that pads a partial block to 8 bytes so the end of a message is always sent.

---
 rtl/usb_tx_block_packer_if.sv | 22 ++
 rtl/usb_tx_block_packer.sv | 135 +++++++++++++
 tb/tb_usb_tx_block_packer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_block_packer_if.sv
// Byte-in / block-out bundle between the encryption datapath, the packer and the USB transmitter.
interface usb_tx_block_packer_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        flush;
  logic        byte_ready;
  logic [63:0] trans_data;
  logic        trans_data_ready;
  logic        handshake_ack;
  logic        ack_error;
  logic [15:0] blocks_sent;

  modport master (
    output byte_in, byte_valid, flush, handshake_ack,
    input  byte_ready, trans_data, trans_data_ready, ack_error, blocks_sent
  );

  modport slave (
    input  byte_in, byte_valid, flush, handshake_ack,
    output byte_ready, trans_data, trans_data_ready, ack_error, blocks_sent
  );
endinterface

// File: rtl/usb_tx_block_packer.sv
// Packs a byte stream into 64-bit blocks, queues them in a small FIFO and hands them
// to the USB transmitter one at a time with a forced idle cycle between blocks.
module usb_tx_block_packer #(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input logic clk,
  input logic rst,
  usb_tx_block_packer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  logic [63:0]      pack_reg;
  logic [2:0]       cnt_reg;
  logic [63:0]      pack_next;
  logic [3:0]       fill_next;
  logic [63:0]      commit_block;
  logic             byte_take;
  logic             flush_take;
  logic             push;
  logic             pop;
  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             byte_ready_reg;
  state_t           state_reg;
  logic [63:0]      trans_data_reg;
  logic             trans_data_ready_reg;
  logic             ack_error_reg;
  logic [15:0]      blocks_sent_reg;

  assign byte_take  = bus.byte_valid & byte_ready_reg;
  assign flush_take = bus.flush & byte_ready_reg;

  // The byte is packed first; the flush decision then looks at the updated fill level.
  always_comb begin
    pack_next = pack_reg;
    fill_next = {1'b0, cnt_reg};
    if (byte_take) begin
      pack_next[{cnt_reg, 3'b000} +: 8] = bus.byte_in;
      fill_next = fill_next + 4'd1;
    end
  end

  assign push = (fill_next == 4'd8) || (flush_take && (fill_next != 4'd0));

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
      assign commit_block[8*gi +: 8] = (4'(gi) < fill_next) ? pack_next[8*gi +: 8] : PAD_BYTE;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      pack_reg <= pack_next;
      cnt_reg  <= push ? 3'd0 : fill_next[2:0];
    end
  end

  assign pop = (state_reg == PRESENT) && bus.handshake_ack;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_reg] <= commit_block;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      byte_ready_reg <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg      <= count_next;
      byte_ready_reg <= (count_next < CNT_W'(DEPTH));
    end
  end

  // The head stays in the FIFO while presented; it is only popped by the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= IDLE;
      trans_data_reg       <= '0;
      trans_data_ready_reg <= 1'b0;
      ack_error_reg        <= 1'b0;
      blocks_sent_reg      <= '0;
    end else begin
      if (bus.handshake_ack && (state_reg != PRESENT)) ack_error_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            trans_data_reg       <= mem[rd_ptr_reg];
            trans_data_ready_reg <= 1'b1;
            state_reg            <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.handshake_ack) begin
            trans_data_ready_reg <= 1'b0;
            blocks_sent_reg      <= blocks_sent_reg + 16'd1;
            state_reg            <= GAP;
          end
        end
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready       = byte_ready_reg;
  assign bus.trans_data       = trans_data_reg;
  assign bus.trans_data_ready = trans_data_ready_reg;
  assign bus.ack_error        = ack_error_reg;
  assign bus.blocks_sent      = blocks_sent_reg;
endmodule

// File: tb/tb_usb_tx_block_packer.sv
// Directed bench for usb_tx_block_packer: expected blocks are queued as bytes are accepted
// and compared when the transmitter side acknowledges them.
module tb_usb_tx_block_packer;
  localparam logic [7:0] PAD = 8'h00;

  logic clk;
  logic rst;
  usb_tx_block_packer_if bus ();

  usb_tx_block_packer #(.DEPTH(2), .PAD_BYTE(PAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          exp_sent = 0;
  logic [63:0] exp_q[$];
  logic [63:0] tb_pack = '0;
  int          tb_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: timed out waiting for DUT", tag);
  endtask

  // Reference packing: runs only for requests the DUT accepted.
  task automatic model(input logic [7:0] b, input logic v, input logic f);
    if (v) begin
      tb_pack[8*tb_cnt +: 8] = b;
      tb_cnt++;
    end
    if (tb_cnt == 8 || (f && tb_cnt > 0)) begin
      for (int k = tb_cnt; k < 8; k++) tb_pack[8*k +: 8] = PAD;
      exp_q.push_back(tb_pack);
      tb_pack = '0;
      tb_cnt  = 0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic v, input logic f);
    int n = 0;
    bus.byte_in    = b;
    bus.byte_valid = v;
    bus.flush      = f;
    while (bus.byte_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) timeout_fail("send");
    else begin
      tick();
      model(b, v, f);
    end
    bus.byte_valid = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output bit ok);
    int n = 0;
    while (bus.trans_data_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    ok = (n < 50);
    if (!ok) timeout_fail(tag);
  endtask

  task automatic take_block(input string tag);
    bit ok;
    wait_ready(tag, ok);
    if (ok) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s: observed block %h expected none", tag, bus.trans_data);
      end else begin
        chk(tag, bus.trans_data, exp_q.pop_front());
      end
      bus.handshake_ack = 1'b1;
      tick();
      bus.handshake_ack = 1'b0;
      exp_sent++;
      chk({tag, "_sent"}, 64'(bus.blocks_sent), 64'(exp_sent));
      $display("block %s acknowledged, blocks_sent=%0d", tag, bus.blocks_sent);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd1);
    chk({tag, "_ready"}, 64'(bus.trans_data_ready), 64'd0);
    chk({tag, "_data"}, bus.trans_data, 64'd0);
    chk({tag, "_ack_error"}, 64'(bus.ack_error), 64'd0);
    chk({tag, "_sent"}, 64'(bus.blocks_sent), 64'd0);
  endtask

  initial begin
    bit ok;
    rst               = 1'b1;
    bus.byte_in       = '0;
    bus.byte_valid    = 1'b0;
    bus.flush         = 1'b0;
    bus.handshake_ack = 1'b0;
    tick();
    tick();
    chk_reset_outputs("rst");
    rst = 1'b0;

    // Eight bytes 01..08: commit edge, then load edge.
    for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b1, 1'b0);
    chk("t1_commit_edge", 64'(bus.trans_data_ready), 64'd0);
    tick();
    chk("t1_load_edge", 64'(bus.trans_data_ready), 64'd1);
    chk("t1_sent_before_ack", 64'(bus.blocks_sent), 64'd0);
    chk("t1_value", bus.trans_data, 64'h0807060504030201);
    take_block("t1_block");

    // Partial block AA BB CC padded by flush; a second flush with empty counter is a no-op.
    send(8'hAA, 1'b1, 1'b0);
    send(8'hBB, 1'b1, 1'b0);
    send(8'hCC, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    chk("t2_value", exp_q[0], 64'h0000000000CCBBAA);
    take_block("t2_block");
    send(8'h00, 1'b0, 1'b1);
    repeat (4) tick();
    chk("t2_no_empty_block", 64'(bus.trans_data_ready), 64'd0);

    // Eighth byte together with flush yields exactly one unpadded block.
    for (int i = 0; i < 7; i++) send(8'(8'h41 + i), 1'b1, 1'b0);
    send(8'h48, 1'b1, 1'b1);
    take_block("t5_block");
    repeat (4) tick();
    chk("t5_single_block", 64'(bus.trans_data_ready), 64'd0);
    chk("t5_ack_error_clear", 64'(bus.ack_error), 64'd0);
    bus.handshake_ack = 1'b1;
    tick();
    bus.handshake_ack = 1'b0;
    chk("t5_ack_error_set", 64'(bus.ack_error), 64'd1);
    chk("t5_sent_unchanged", 64'(bus.blocks_sent), 64'(exp_sent));

    // Withheld ack: FIFO fills, upstream stalls, one ack reopens byte_ready.
    for (int i = 0; i < 16; i++) send(8'(8'h60 + i), 1'b1, 1'b0);
    chk("t3_ready_low", 64'(bus.byte_ready), 64'd0);
    bus.byte_in    = 8'h70;
    bus.byte_valid = 1'b1;
    repeat (3) tick();
    chk("t3_still_stalled", 64'(bus.byte_ready), 64'd0);
    chk("t3_head_stable", bus.trans_data, exp_q[0]);
    take_block("t3_blk1");
    chk("t3_ready_back", 64'(bus.byte_ready), 64'd1);
    for (int i = 0; i < 8; i++) send(8'(8'h70 + i), 1'b1, 1'b0);
    take_block("t3_blk2");
    take_block("t3_blk3");

    // Ack held three cycles: ready 1, 0 (gap), 0 (idle load), 1; only one pop.
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b1, 1'b0);
    wait_ready("t4_wait", ok);
    if (ok) begin
      chk("t4_blk1", bus.trans_data, exp_q.pop_front());
      bus.handshake_ack = 1'b1;
      tick();
      chk("t4_gap", 64'(bus.trans_data_ready), 64'd0);
      tick();
      chk("t4_idle", 64'(bus.trans_data_ready), 64'd0);
      tick();
      chk("t4_reload", 64'(bus.trans_data_ready), 64'd1);
      bus.handshake_ack = 1'b0;
      exp_sent++;
      chk("t4_sent", 64'(bus.blocks_sent), 64'(exp_sent));
      chk("t4_blk2_held", bus.trans_data, exp_q[0]);
      tick();
      chk("t4_one_pop", 64'(bus.blocks_sent), 64'(exp_sent));
      take_block("t4_blk2");
    end

    // Reset during presentation with a partial block pending.
    for (int i = 0; i < 8; i++) send(8'(8'h90 + i), 1'b1, 1'b0);
    wait_ready("t6_wait", ok);
    for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_reset_outputs("t6_rst");
    rst = 1'b0;
    exp_q.delete();
    tb_pack  = '0;
    tb_cnt   = 0;
    exp_sent = 0;
    for (int i = 0; i < 8; i++) send(8'(8'hB0 + i), 1'b1, 1'b0);
    chk("t6_clean_value", exp_q[0], 64'hB7B6B5B4B3B2B1B0);
    take_block("t6_clean");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
